// File: rtl/mips_fetch_stage.sv
`timescale 1ns/1ps
package mips_fetch_pkg;
    typedef struct packed {
        logic clk;
        logic rst;
    } Data_Control_T;
endpackage

// MIPS fetch: owns the fetch PC, drives a registered-address ROM, buffers words in out + skid registers.
// Latency: a word is on out two rising edges after its fetch is issued; sustains one instruction per cycle.
// Backpressure: out_ready low holds the outputs, catches the in-flight word in skid, and stops issue.
module mips_fetch_stage
    import mips_fetch_pkg::*;
#(
    parameter int              ADDR_W     = 32,
    parameter int              ROM_ADDR_W = 6,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  Data_Control_T          ctrl,
    output logic [ROM_ADDR_W-1:0]  rom_addr,
    input  logic [31:0]            rom_data,
    input  logic                   redirect,
    input  logic [ADDR_W-1:0]      redirect_addr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_inst,
    output logic [ADDR_W-1:0]      out_pc,
    output logic [ADDR_W-1:0]      out_pc4
);
    localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] PC_ALIGN = ~ADDR_W'(3);

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] fpc;
    logic              req_valid;
    logic [ADDR_W-1:0] req_pc;
    logic              skid_valid;
    logic [31:0]       skid_inst;
    logic [ADDR_W-1:0] skid_pc;
    logic [ADDR_W-1:0] redir_pc;
    logic              out_free;
    logic              issue;

    assign clk      = ctrl.clk;
    assign rst      = ctrl.rst;
    assign redir_pc = redirect_addr & PC_ALIGN;
    assign rom_addr = redirect ? redirect_addr[ROM_ADDR_W+1:2] : fpc[ROM_ADDR_W+1:2];
    assign out_free = !out_valid || out_ready;
    // Hold off issue whenever the word it would fetch might find no free buffer slot.
    assign issue    = !skid_valid && !(out_valid && !out_ready && req_valid);
    assign out_pc4  = out_pc + PC_STEP;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpc        <= RESET_PC;
            req_valid  <= 1'b0;
            req_pc     <= '0;
            out_valid  <= 1'b0;
            out_inst   <= '0;
            out_pc     <= '0;
            skid_valid <= 1'b0;
            skid_inst  <= '0;
            skid_pc    <= '0;
        end else if (redirect) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            req_valid  <= 1'b1;
            req_pc     <= redir_pc;
            fpc        <= redir_pc + PC_STEP;
        end else begin
            req_valid <= issue;
            if (issue) begin
                req_pc <= fpc;
                fpc    <= fpc + PC_STEP;
            end
            if (out_free) begin
                if (skid_valid) begin
                    out_valid  <= 1'b1;
                    out_inst   <= skid_inst;
                    out_pc     <= skid_pc;
                    skid_valid <= req_valid;
                    if (req_valid) begin
                        skid_inst <= rom_data;
                        skid_pc   <= req_pc;
                    end
                end else if (req_valid) begin
                    out_valid <= 1'b1;
                    out_inst  <= rom_data;
                    out_pc    <= req_pc;
                end else begin
                    out_valid <= 1'b0;
                end
            end else if (req_valid) begin
                skid_valid <= 1'b1;
                skid_inst  <= rom_data;
                skid_pc    <= req_pc;
            end
        end
    end
endmodule
